// File: rtl/vt52_video_pkg.sv
// Shared constants and types for the VT52-style character-cell video path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vt52_video_pkg;

    localparam int COLS     = 64;
    localparam int ROWS     = 16;
    localparam int CELL_W   = 8;
    localparam int CELL_H   = 16;
    localparam int CHAR_AW  = 10;
    localparam int FONT_AW  = 11;
    localparam int PIPE_LAT = 5;

    localparam int HBP_DEFAULT          = 112;
    localparam int VBP_DEFAULT          = 145;
    localparam int BLINK_FRAMES_DEFAULT = 30;

    // Per-pixel side information carried alongside the memory fetches.
    typedef struct packed {
        logic [2:0] sub;    // pixel column within the glyph row
        logic [3:0] grow;   // glyph row within the cell
        logic       blank;
        logic       hsync;
        logic       vsync;
        logic       cur;    // cursor covers this pixel
    } pipe_t;

    // Idle state: blanked, syncs deasserted (high), no cursor.
    localparam pipe_t PIPE_RST = '{sub: 3'd0, grow: 4'd0, blank: 1'b1,
                                   hsync: 1'b1, vsync: 1'b1, cur: 1'b0};

    function automatic logic [CHAR_AW-1:0] cell_addr(input logic [3:0] row,
                                                     input logic [5:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/cursor_blinker.sv
// Cursor blink phase: toggles every BLINK_FRAMES falling edges of vsync.
// Latency: phase changes the cycle after the qualifying vsync fall.
// Backpressure: none; free-running.
module cursor_blinker #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic px_clk,
    input  logic clr_n,
    input  logic vsync,
    output logic phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic          vs_prev_q, vs_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          frame_tick;

    // Frame tick on vsync 1->0; counter wraps at BLINK_FRAMES-1 and flips the phase.
    always_comb begin
        vs_prev_d  = vsync;
        frame_tick = vs_prev_q & ~vsync;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        if (frame_tick) begin
            if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Blink state registers; cursor starts visible.
    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            vs_prev_q <= 1'b1;
            cnt_q     <= '0;
            phase_q   <= 1'b1;
        end else begin
            vs_prev_q <= vs_prev_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/video_generator.sv
// Character-cell monochrome pixel generator with blinking block cursor; optional VIDEO_INVERSE_EN (code bit 7 = inverse video).
// Latency: exactly 5 px_clk from hc/vc/blank/sync input to pixel and delayed syncs/blank.
// Backpressure: none; one pixel per px_clk, never stalls.
module video_generator
    import vt52_video_pkg::*;
#(
    parameter int HBP          = HBP_DEFAULT,
    parameter int VBP          = VBP_DEFAULT,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
    input  logic               px_clk,
    input  logic               clr_n,
    input  logic [10:0]        hc,
    input  logic [10:0]        vc,
    input  logic               hblank,
    input  logic               vblank,
    input  logic               hsync,
    input  logic               vsync,
    output logic [CHAR_AW-1:0] char_addr,
    input  logic [7:0]         char_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    input  logic [5:0]         cursor_x,
    input  logic [3:0]         cursor_y,
    input  logic               cursor_en,
    output logic               pixel,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_out
);

    localparam int NSTG = PIPE_LAT - 1;   // side-info stages before the output register

    logic [10:0] x_w, y_w;
    logic [5:0]  col;
    logic [2:0]  sub;
    logic [3:0]  row, grow;
    logic        blank_in;
    logic        phase;
    logic        cur_hit;
    logic        inv_d4;
    logic        font_bit;
    pipe_t       stage_in;

    pipe_t [NSTG-1:0]    pipe_q, pipe_d;
    logic [CHAR_AW-1:0]  char_addr_q, char_addr_d;
    logic [FONT_AW-1:0]  font_addr_q, font_addr_d;
    logic                pixel_q, pixel_d;
    logic                hsync_out_q, hsync_out_d;
    logic                vsync_out_q, vsync_out_d;
    logic                blank_out_q, blank_out_d;

    cursor_blinker #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .px_clk (px_clk),
        .clr_n  (clr_n),
        .vsync  (vsync),
        .phase  (phase)
    );

    // Screen coordinates and cell decomposition; bits above the cell grid wrap silently.
    always_comb begin
        x_w      = hc - 11'(HBP);
        y_w      = vc - 11'(VBP);
        col      = x_w[8:3];
        sub      = x_w[2:0];
        row      = y_w[7:4];
        grow     = y_w[3:0];
        blank_in = hblank | vblank;
        cur_hit  = cursor_en & phase & (col == cursor_x) & (row == cursor_y) & ~blank_in;
        stage_in = '{sub: sub, grow: grow, blank: blank_in,
                     hsync: hsync, vsync: vsync, cur: cur_hit};
    end

    // Stage 0: char address (held through blanking) and side-info pipe shift.
    always_comb begin
        char_addr_d = blank_in ? char_addr_q : cell_addr(row, col);
        pipe_d      = {pipe_q[NSTG-2:0], stage_in};
    end

    // Stage 2: glyph row fetch once the character code has returned.
    always_comb begin
        font_addr_d = {char_data[6:0], pipe_q[1].grow};
    end

`ifdef VIDEO_INVERSE_EN
    logic [1:0] inv_q, inv_d;
    logic       unused_bits;

    // Inverse flag rides with the font fetch so it lines up with font_data.
    always_comb begin
        inv_d = {inv_q[0], char_data[7]};
    end

    // Inverse flag registers.
    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            inv_q <= '0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign inv_d4      = inv_q[1];
    assign unused_bits = ^{x_w[10:9], y_w[10:8]};
`else
    logic unused_bits;

    assign inv_d4      = 1'b0;
    assign unused_bits = ^{char_data[7], x_w[10:9], y_w[10:8]};
`endif

    // Stage 4: pick the glyph bit, apply cursor and inverse, force dark while blanked.
    always_comb begin
        font_bit    = font_data[3'd7 - pipe_q[NSTG-1].sub];
        pixel_d     = pipe_q[NSTG-1].blank ? 1'b0 : (font_bit ^ pipe_q[NSTG-1].cur ^ inv_d4);
        hsync_out_d = pipe_q[NSTG-1].hsync;
        vsync_out_d = pipe_q[NSTG-1].vsync;
        blank_out_d = pipe_q[NSTG-1].blank;
    end

    // Pipeline registers; reset empties the pipe into the blanked, sync-idle state.
    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            pipe_q      <= {NSTG{PIPE_RST}};
            char_addr_q <= '0;
            font_addr_q <= '0;
            pixel_q     <= 1'b0;
            hsync_out_q <= 1'b1;
            vsync_out_q <= 1'b1;
            blank_out_q <= 1'b1;
        end else begin
            pipe_q      <= pipe_d;
            char_addr_q <= char_addr_d;
            font_addr_q <= font_addr_d;
            pixel_q     <= pixel_d;
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
            blank_out_q <= blank_out_d;
        end
    end

    assign char_addr = char_addr_q;
    assign font_addr = font_addr_q;
    assign pixel     = pixel_q;
    assign hsync_out = hsync_out_q;
    assign vsync_out = vsync_out_q;
    assign blank_out = blank_out_q;

endmodule

// File: tb/tb_video_generator.sv
// Directed bench for video_generator with behavioural char buffer and font ROM.
// Latency: inputs applied on negedge k appear on registered outputs at negedge k+5.
// Backpressure: n/a.
module tb_video_generator;

    logic        px_clk = 1'b0;
    logic        clr_n;
    logic [10:0] hc, vc;
    logic        hblank, vblank, hsync, vsync;
    logic [9:0]  char_addr;
    logic [7:0]  char_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [5:0]  cursor_x;
    logic [3:0]  cursor_y;
    logic        cursor_en;
    logic        pixel, hsync_out, vsync_out, blank_out;

    logic [7:0]  char_mem [0:1023];
    logic [7:0]  font_mem [0:2047];
    logic        got [0:31];

    int checks = 0;
    int errors = 0;

    video_generator dut (
        .px_clk    (px_clk),
        .clr_n     (clr_n),
        .hc        (hc),
        .vc        (vc),
        .hblank    (hblank),
        .vblank    (vblank),
        .hsync     (hsync),
        .vsync     (vsync),
        .char_addr (char_addr),
        .char_data (char_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .cursor_en (cursor_en),
        .pixel     (pixel),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .blank_out (blank_out)
    );

    always #5 px_clk = ~px_clk;

    // One-cycle registered reads, like the real buffer and ROM.
    always @(posedge px_clk) begin
        char_data <= char_mem[char_addr];
        font_data <= font_mem[font_addr];
    end

    task automatic cyc(input int h, input int v, input logic hb, input logic vb,
                       input logic hs, input logic vs);
        @(negedge px_clk);
        hc     = 11'(h);
        vc     = 11'(v);
        hblank = hb;
        vblank = vb;
        hsync  = hs;
        vsync  = vs;
    endtask

    task automatic fill_font(input logic [7:0] val);
        for (int i = 0; i < 2048; i++) font_mem[i] = val;
    endtask

    task automatic clear_chars();
        for (int i = 0; i < 1024; i++) char_mem[i] = 8'h00;
    endtask

    // Drive n visible pixels on line v from h0, then blank; got[j] is pixel for input j.
    task automatic scan(input int v, input int h0, input int n);
        for (int i = 0; i < n + 5; i++) begin
            if (i < n) cyc(h0 + i, v, 1'b0, 1'b0, 1'b1, 1'b1);
            else       cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (i >= 5) got[i-5] = pixel;
        end
    endtask

    task automatic vs_falls(input int n);
        repeat (n) begin
            cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
            cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic test_reset();
        // Power-on state while held in reset.
        repeat (3) cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({char_addr, font_addr, pixel, hsync_out, vsync_out, blank_out} !== {10'd0, 11'd0, 4'b0111}) begin
            errors++;
            $display("FAIL reset_init: got ca=%0d fa=%0d px=%b hs=%b vs=%b bl=%b, want 0 0 0 1 1 1",
                     char_addr, font_addr, pixel, hsync_out, vsync_out, blank_out);
        end
        @(negedge px_clk);
        clr_n = 1'b1;
        // Lit visible line with hsync low, then reset mid-line.
        fill_font(8'hFF);
        for (int i = 0; i < 8; i++) begin
            cyc(112 + i, 145, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 6) begin
                checks++;
                if ({pixel, hsync_out, blank_out} !== 3'b100) begin
                    errors++;
                    $display("FAIL prereset_out: got px=%b hs=%b bl=%b, want 1 0 0", pixel, hsync_out, blank_out);
                end
            end
        end
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if ({pixel, hsync_out, vsync_out, blank_out, char_addr} !== {4'b0111, 10'd0}) begin
            errors++;
            $display("FAIL reset_async: got px=%b hs=%b vs=%b bl=%b ca=%0d, want 0 1 1 1 0",
                     pixel, hsync_out, vsync_out, blank_out, char_addr);
        end
        // Release; first five outputs must still be blank.
        for (int k = 0; k < 6; k++) begin
            cyc(112 + k, 145, 1'b0, 1'b0, 1'b1, 1'b1);
            if (k == 0) clr_n = 1'b1;
            checks++;
            if (blank_out !== (k < 5) || pixel !== (k == 5)) begin
                errors++;
                $display("FAIL reset_release k=%0d: got bl=%b px=%b, want bl=%b px=%b",
                         k, blank_out, pixel, (k < 5), (k == 5));
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] g;
        g = 8'h18;
        fill_font(8'h00);
        clear_chars();
        char_mem[0] = 8'h41;
        font_mem[11'h410] = 8'h18;
        cyc(112 + 24, 145, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (char_addr !== 10'd3) begin
            errors++;
            $display("FAIL char_addr_hold: got %0d want 3", char_addr);
        end
        for (int i = 0; i < 13; i++) begin
            cyc(112 + i, 145, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i == 1) begin
                checks++;
                if (char_addr !== 10'd0) begin
                    errors++;
                    $display("FAIL lat_char_addr: got %0d want 0", char_addr);
                end
            end
            if (i == 3) begin
                checks++;
                if (font_addr !== 11'h410) begin
                    errors++;
                    $display("FAIL lat_font_addr: got %h want 410", font_addr);
                end
            end
            if (i >= 5) begin
                checks++;
                if (pixel !== g[7-(i-5)]) begin
                    errors++;
                    $display("FAIL lat_pixel j=%0d: got %b want %b", i - 5, pixel, g[7-(i-5)]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        char_mem[1023] = 8'h5A;
        font_mem[11'h5AF] = 8'h01;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) cyc(112 + 511, 145 + 255, 1'b0, 1'b0, 1'b1, 1'b1);
            else        cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
            if (i == 1) begin
                checks++;
                if (char_addr !== 10'd1023) begin
                    errors++;
                    $display("FAIL wrap_char_addr: got %0d want 1023", char_addr);
                end
            end
            if (i == 3) begin
                checks++;
                if (font_addr !== 11'h5AF) begin
                    errors++;
                    $display("FAIL wrap_font_addr: got %h want 5af", font_addr);
                end
            end
            if (i == 5) begin
                checks++;
                if (pixel !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_pixel: got %b want 1", pixel);
                end
            end
        end
        cyc(112, 145, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (char_addr !== 10'd0) begin
            errors++;
            $display("FAIL wrap_next_line: got %0d want 0", char_addr);
        end
    endtask

    task automatic test_blanking();
        logic hb_h [0:34];
        logic hs_h [0:34];
        logic vs_h [0:34];
        fill_font(8'hFF);
        for (int i = 0; i < 35; i++) begin
            hb_h[i] = (i >= 10 && i < 18);
            hs_h[i] = !(i >= 20 && i < 24);
            vs_h[i] = !(i >= 25 && i < 27);
            cyc(112 + i, 150, hb_h[i], 1'b0, hs_h[i], vs_h[i]);
            if (i >= 5) begin
                checks++;
                if (blank_out !== hb_h[i-5] || pixel !== !hb_h[i-5] ||
                    hsync_out !== hs_h[i-5] || vsync_out !== vs_h[i-5]) begin
                    errors++;
                    $display("FAIL blank_win i=%0d: got bl=%b px=%b hs=%b vs=%b want %b %b %b %b",
                             i, blank_out, pixel, hsync_out, vsync_out,
                             hb_h[i-5], !hb_h[i-5], hs_h[i-5], vs_h[i-5]);
                end
            end
        end
    endtask

    task automatic test_cursor();
        int vl [0:2];
        vl[0] = 177; vl[1] = 192; vl[2] = 193;
        @(negedge px_clk) clr_n = 1'b0;
        @(negedge px_clk) clr_n = 1'b1;
        fill_font(8'h00);
        clear_chars();
        cursor_en = 1'b1;
        cursor_x  = 6'd5;
        cursor_y  = 4'd2;
        for (int r = 0; r < 3; r++) begin
            scan(vl[r], 148, 16);
            for (int j = 0; j < 16; j++) begin
                checks++;
                if (got[j] !== (vl[r] <= 192 && (148 + j) >= 152 && (148 + j) <= 159)) begin
                    errors++;
                    $display("FAIL cursor_on vc=%0d hc=%0d: got %b", vl[r], 148 + j, got[j]);
                end
            end
        end
        vs_falls(29);
        scan(180, 152, 8);
        checks++;
        if (got[0] !== 1'b1 || got[7] !== 1'b1) begin
            errors++;
            $display("FAIL cursor_29: got %b%b want 11", got[0], got[7]);
        end
        vs_falls(1);
        scan(180, 151, 10);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (got[j] !== 1'b0) begin
                errors++;
                $display("FAIL cursor_off hc=%0d: got %b want 0", 151 + j, got[j]);
            end
        end
        vs_falls(15);
        cursor_x = 6'd6;
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        cursor_x = 6'd5;
        vs_falls(15);
        scan(180, 151, 10);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (got[j] !== (j >= 1 && j <= 8)) begin
                errors++;
                $display("FAIL cursor_60 hc=%0d: got %b want %b", 151 + j, got[j], (j >= 1 && j <= 8));
            end
        end
    endtask

    task automatic test_inverse();
        logic [7:0] plain, with_cur;
`ifdef VIDEO_INVERSE_EN
        plain = 8'hE7;
        with_cur = 8'h18;
`else
        plain = 8'h18;
        with_cur = 8'hE7;
`endif
        char_mem[2*64 + 5] = 8'hC1;
        font_mem[11'h410]  = 8'h18;
        cursor_en = 1'b0;
        scan(177, 152, 8);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (got[j] !== plain[7-j]) begin
                errors++;
                $display("FAIL inverse_plain j=%0d: got %b want %b", j, got[j], plain[7-j]);
            end
        end
        cursor_en = 1'b1;
        scan(177, 152, 8);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (got[j] !== with_cur[7-j]) begin
                errors++;
                $display("FAIL inverse_cursor j=%0d: got %b want %b", j, got[j], with_cur[7-j]);
            end
        end
    endtask

    initial begin
        clr_n     = 1'b0;
        hc        = '0;
        vc        = '0;
        hblank    = 1'b1;
        vblank    = 1'b1;
        hsync     = 1'b1;
        vsync     = 1'b1;
        cursor_x  = '0;
        cursor_y  = '0;
        cursor_en = 1'b0;
        clear_chars();
        fill_font(8'h00);
        test_reset();
        test_latency();
        test_wrap();
        test_blanking();
        test_cursor();
        test_inverse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
